rlbp_cmp_reader: RTL and testbench

RLBP_CMP_READER -- requirements
Module: rlbp_cmp_reader

---
 rtl/rlbp_pkg.sv | 36 +++
 rtl/rlbp_code_fifo.sv | 82 ++++++++
 rtl/rlbp_cmp_reader.sv | 245 ++++++++++++++++++++++++
 tb/tb_rlbp_cmp_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rlbp_pkg.sv
// rlbp_pkg -- shared definitions for the RLBP comparator reader.
//
// Contents:
//   - Wishbone register offsets (word index taken from wbs_adr_i[3:2])
//   - STATUS and CTRL field bit positions
//   - capture FSM state encoding
//   - IRQ threshold reset value
package rlbp_pkg;

   // Register map, indexed by wbs_adr_i[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   // STATUS fields
   localparam int ST_EMPTY_BIT  = 0;
   localparam int ST_OVF_BIT    = 1;
   localparam int ST_LEVEL_LSB  = 4;   // 8-bit FIFO level
   localparam int ST_ABORT_LSB  = 16;  // 8-bit abort counter

   // CTRL fields
   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_OVF_CLR_BIT = 1;  // write-1-clears ovf, reads 0
   localparam int CTRL_THR_LSB     = 4;  // 4-bit irq threshold

   localparam logic [3:0] IRQ_THR_RST = 4'd4;

   // Capture FSM
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_PUSH    = 2'd2
   } cap_state_e;

endpackage

// File: rtl/rlbp_code_fifo.sv
// rlbp_code_fifo -- synchronous show-ahead FIFO for tagged LBP codes.
//
// Ports:
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset (empties the FIFO)
//   push_i   : write request; accepted when not full, or when full and a
//              pop is accepted in the same cycle
//   wdata_i  : word to write
//   pop_i    : read request; ignored when empty
//   rdata_o  : head word, valid whenever empty_o is low
//   level_o  : number of stored words (0..DEPTH)
//   full_o   : level_o == DEPTH
//   empty_o  : level_o == 0
//
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module rlbp_code_fifo
   import rlbp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == FULL_LVL);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A full FIFO still takes a write when the head leaves in the same cycle:
   // the head slot is read combinationally before the edge overwrites it.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset; only words below level_o are ever observed.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/rlbp_cmp_reader.sv
// rlbp_cmp_reader -- collects NBITS comparator decisions per LBP code into a
// tagged FIFO and exposes it through a Wishbone slave.
//
// Ports:
//   wb_clk_i      : sole clock
//   wb_rst_i      : synchronous active-low reset
//   cmp_i         : asynchronous comparator output (2-flop synchronised)
//   start_i       : one-cycle pulse, begins a new code (aborts a partial one)
//   cmp_strobe_i  : one-cycle pulse, comparator decision valid
//   wbs_cyc_i/stb_i/we_i/adr_i/dat_i/sel_i : Wishbone request
//   wbs_ack_o/dat_o                        : Wishbone response
//   irq_o         : FIFO-level interrupt
//
// Registers (wbs_adr_i[3:2]):
//   0 DATA   read pops, {16'b0, tag[3:0], code}; 0 when empty (no pop)
//   1 STATUS {abort_cnt @23:16, level @11:4, ovf @1, empty @0}
//   2 CTRL   en @0, ovf write-1-clear @1, irq_thr @7:4 (byte lane 0)
//   3        reads 0, writes ignored
//
// Build option: define RLBP_READER_IRQ_EN to enable the registered
// interrupt irq_o = (level >= irq_thr) | ovf. Without it irq_o is 0 and
// irq_thr reads as 0 and cannot be written.
module rlbp_cmp_reader
   import rlbp_pkg::*;
#(
   parameter int NBITS = 12,
   parameter int DEPTH = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmp_i,
   input  logic        start_i,
   input  logic        cmp_strobe_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [3:0]  wbs_sel_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        irq_o
);

   localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int FW = 4 + NBITS;

   // ---------------- comparator synchroniser ----------------
   logic cmp_s1_q, cmp_s_q;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         cmp_s1_q <= 1'b0;
         cmp_s_q  <= 1'b0;
      end else begin
         cmp_s1_q <= cmp_i;
         cmp_s_q  <= cmp_s1_q;
      end
   end

   // ---------------- state ----------------
   cap_state_e       state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [NBITS-1:0] code_q, code_d;
   logic [3:0]       tag_q, tag_d;
   logic [7:0]       abort_cnt_q, abort_cnt_d;
   logic             ovf_q, ovf_d;
   logic             en_q, en_d;
   logic             ack_q, req_seen_q;
   logic [31:0]      dat_q;
   logic [3:0]       irq_thr;

   // FIFO
   logic             push;
   logic             pop;
   logic [FW-1:0]    fifo_rdata;
   logic [LW-1:0]    fifo_level;
   logic             fifo_full, fifo_empty;
   logic [7:0]       level8;

   assign level8 = 8'(fifo_level);

   // ---------------- Wishbone handshake ----------------
   // A request (cyc & stb) is accepted on the first edge it is seen high;
   // all side effects (pop, CTRL write) happen on that edge and ack plus
   // read data appear for exactly the following cycle. req_seen_q blocks a
   // second acceptance until stb has been seen low at an edge.
   logic       wb_req, wb_acc, wb_rd, wb_wr, ctrl_wr;
   logic [1:0] reg_sel;
   logic [31:0] rd_word;

   assign wb_req  = wbs_cyc_i & wbs_stb_i;
   assign wb_acc  = wb_req & ~req_seen_q;
   assign wb_rd   = wb_acc & ~wbs_we_i;
   assign wb_wr   = wb_acc & wbs_we_i;
   assign reg_sel = wbs_adr_i[3:2];
   assign pop     = wb_rd & (reg_sel == REG_DATA) & ~fifo_empty;
   // All CTRL fields live in byte lane 0.
   assign ctrl_wr = wb_wr & (reg_sel == REG_CTRL) & wbs_sel_i[0];

   always_comb begin
      logic [31:0] status_w;
      logic [31:0] ctrl_w;
      status_w = '0;
      status_w[ST_EMPTY_BIT]        = fifo_empty;
      status_w[ST_OVF_BIT]          = ovf_q;
      status_w[ST_LEVEL_LSB +: 8]   = level8;
      status_w[ST_ABORT_LSB +: 8]   = abort_cnt_q;
      ctrl_w = '0;
      ctrl_w[CTRL_EN_BIT]           = en_q;
      ctrl_w[CTRL_THR_LSB +: 4]     = irq_thr;
      case (reg_sel)
         REG_DATA:   rd_word = fifo_empty ? 32'd0 : 32'(fifo_rdata);
         REG_STATUS: rd_word = status_w;
         REG_CTRL:   rd_word = ctrl_w;
         default:    rd_word = 32'd0;
      endcase
   end

   // ---------------- capture FSM ----------------
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      code_d      = code_q;
      tag_d       = tag_q;
      abort_cnt_d = abort_cnt_q;
      push        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && en_q) begin
               state_d = S_COLLECT;
               k_d     = '0;
               code_d  = '0;
            end
         end
         S_COLLECT: begin
            // A new start wins over a coincident strobe: the code restarts.
            if (start_i) begin
               k_d    = '0;
               code_d = '0;
               if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
            end else if (cmp_strobe_i) begin
               code_d[k_q] = cmp_s_q;
               if (k_q == KW'(NBITS-1)) begin
                  state_d = S_PUSH;
                  k_d     = '0;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         S_PUSH: begin
            push    = 1'b1;
            tag_d   = tag_q + 4'd1;   // advances even when the code is dropped
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- control register next state ----------------
   always_comb begin
      en_d  = en_q;
      ovf_d = ovf_q;
      if (ctrl_wr) begin
         en_d = wbs_dat_i[CTRL_EN_BIT];
         if (wbs_dat_i[CTRL_OVF_CLR_BIT]) ovf_d = 1'b0;
      end
      // A drop in the same cycle as a clear keeps ovf set.
      if (push && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         code_q      <= '0;
         tag_q       <= '0;
         abort_cnt_q <= '0;
         ovf_q       <= 1'b0;
         en_q        <= 1'b0;
         ack_q       <= 1'b0;
         req_seen_q  <= 1'b0;
         dat_q       <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         code_q      <= code_d;
         tag_q       <= tag_d;
         abort_cnt_q <= abort_cnt_d;
         ovf_q       <= ovf_d;
         en_q        <= en_d;
         ack_q       <= wb_acc;
         req_seen_q  <= wb_req;
         dat_q       <= wb_rd ? rd_word : 32'd0;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

   // ---------------- interrupt ----------------
`ifdef RLBP_READER_IRQ_EN
   logic [3:0] irq_thr_q;
   logic       irq_q;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         irq_thr_q <= IRQ_THR_RST;
         irq_q     <= 1'b0;
      end else begin
         if (ctrl_wr) irq_thr_q <= wbs_dat_i[CTRL_THR_LSB +: 4];
         irq_q <= (level8 >= {4'd0, irq_thr_q}) | ovf_q;
      end
   end

   assign irq_thr = irq_thr_q;
   assign irq_o   = irq_q;
`else
   assign irq_thr = 4'd0;
   assign irq_o   = 1'b0;
`endif

   // ---------------- code FIFO ----------------
   rlbp_code_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_i),
      .push_i  (push),
      .wdata_i ({tag_q, code_q}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Address/data/select bits outside the decoded fields are don't-care.
   logic unused_ok;
   assign unused_ok = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

endmodule

// File: tb/tb_rlbp_cmp_reader.sv
// tb_rlbp_cmp_reader -- self-checking bench for rlbp_cmp_reader.
// Covers reset state, code capture (table of patterns), abort handling,
// FIFO overflow, simultaneous push/pop at full, register access rules,
// mid-code reset and the optional interrupt (RLBP_READER_IRQ_EN).
module tb_rlbp_cmp_reader;

   localparam logic [1:0] R_DATA   = 2'd0;
   localparam logic [1:0] R_STATUS = 2'd1;
   localparam logic [1:0] R_CTRL   = 2'd2;
   localparam logic [1:0] R_RSVD   = 2'd3;
`ifdef RLBP_READER_IRQ_EN
   localparam logic [31:0] CTRL_RST = 32'h0000_0040;
   localparam logic [31:0] CTRL_EN1 = 32'h0000_0041;
`else
   localparam logic [31:0] CTRL_RST = 32'h0000_0000;
   localparam logic [31:0] CTRL_EN1 = 32'h0000_0001;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b0;
   logic        cmp_i = 1'b0;
   logic        start_i = 1'b0;
   logic        cmp_strobe_i = 1'b0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_we_i = 1'b0;
   logic [31:0] wbs_adr_i = '0;
   logic [31:0] wbs_dat_i = '0;
   logic [3:0]  wbs_sel_i = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        irq_o;

   always #5 wb_clk_i = ~wb_clk_i;

   rlbp_cmp_reader #(.NBITS(12), .DEPTH(8)) dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .cmp_i        (cmp_i),
      .start_i      (start_i),
      .cmp_strobe_i (cmp_strobe_i),
      .wbs_cyc_i    (wbs_cyc_i),
      .wbs_stb_i    (wbs_stb_i),
      .wbs_we_i     (wbs_we_i),
      .wbs_adr_i    (wbs_adr_i),
      .wbs_dat_i    (wbs_dat_i),
      .wbs_sel_i    (wbs_sel_i),
      .wbs_ack_o    (wbs_ack_o),
      .wbs_dat_o    (wbs_dat_o),
      .irq_o        (irq_o)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [3:0]  m_tag = '0;

   typedef struct {
      logic [11:0] pat;   // bit k = comparator value at strobe k
      logic [31:0] exp;   // expected DATA word
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Expected word for the next code, pushed when the code is driven.
   task automatic model_push(input logic [11:0] p);
      if (exp_q.size() < 8) exp_q.push_back({16'd0, m_tag, p});
      m_tag = m_tag + 4'd1;
   endtask

   // ---------------- driver tasks (enter and leave at a negedge) ----------------
   task automatic do_reset();
      wb_rst_i = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      exp_q.delete();
      m_tag = '0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge wb_clk_i);
      start_i = 1'b0;
   endtask

   // cmp_i needs two edges through the synchroniser before the strobe.
   task automatic strobe(input logic v);
      cmp_i = v;
      repeat (2) @(negedge wb_clk_i);
      cmp_strobe_i = 1'b1;
      @(negedge wb_clk_i);
      cmp_strobe_i = 1'b0;
   endtask

   task automatic send_bits(input logic [11:0] p, input int n);
      for (int k = 0; k < n; k++) strobe(p[k]);
   endtask

   // Full code, then wait until it is in the FIFO.
   task automatic send_code(input logic [11:0] p);
      pulse_start();
      send_bits(p, 12);
      repeat (2) @(negedge wb_clk_i);
   endtask

   task automatic wb_access(input logic we, input logic [1:0] r, input logic [31:0] wd,
                            input logic [3:0] sel, output logic [31:0] rd);
      logic got;
      got = 1'b0;
      rd  = '0;
      wbs_adr_i = {28'd0, r, 2'b00};
      wbs_dat_i = wd;
      wbs_sel_i = sel;
      wbs_we_i  = we;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge wb_clk_i);
         #1;
         if (wbs_ack_o) begin
            rd  = wbs_dat_o;
            got = 1'b1;
            break;
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL wb_ack_timeout: got no ack expected ack within 8 cycles");
      end
      // stb must be seen low at an edge before the next request
      repeat (2) @(negedge wb_clk_i);
   endtask

   task automatic wb_read(input logic [1:0] r, output logic [31:0] rd);
      wb_access(1'b0, r, 32'd0, 4'hF, rd);
   endtask

   task automatic wb_write(input logic [1:0] r, input logic [31:0] wd, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_access(1'b1, r, wd, sel, dummy);
   endtask

   task automatic read_check(input string name, input logic [1:0] r, input logic [31:0] exp);
      logic [31:0] d;
      wb_read(r, d);
      check(name, d, exp);
   endtask

   // DATA read compared against the head of the expected queue (0 if empty).
   task automatic read_data_check(input string name);
      logic [31:0] d;
      logic [31:0] e;
      e = (exp_q.size() == 0) ? 32'd0 : exp_q.pop_front();
      wb_read(R_DATA, d);
      check(name, d, e);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [11:0] p;
      logic [31:0] d;
      int          acks;
      logic        first_ack;
      logic [31:0] idle_dat;

      tbl[0] = '{pat: 12'h80D, exp: 32'h0000_080D};
      tbl[1] = '{pat: 12'hFFF, exp: 32'h0000_1FFF};
      tbl[2] = '{pat: 12'h000, exp: 32'h0000_2000};
      tbl[3] = '{pat: 12'hA5C, exp: 32'h0000_3A5C};
      tbl[4] = '{pat: 12'h001, exp: 32'h0000_4001};
      tbl[5] = '{pat: 12'h800, exp: 32'h0000_5800};

      // Reset state
      do_reset();
      check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rst_dat", wbs_dat_o, 32'd0);
      check("rst_irq", {31'd0, irq_o}, 32'd0);
      read_check("rst_status", R_STATUS, 32'h0000_0001);
      read_check("rst_ctrl", R_CTRL, CTRL_RST);

      // Disabled: start is ignored, nothing captured
      send_code(12'h123);
      read_check("dis_status", R_STATUS, 32'h0000_0001);
      read_data_check("dis_data");

      // Table of patterns; a stray strobe in IDLE precedes each code
      wb_write(R_CTRL, 32'h0000_0001, 4'hF);
      for (int i = 0; i < 6; i++) begin
         strobe(1'b1);
         exp_q.push_back(tbl[i].exp);
         m_tag = m_tag + 4'd1;
         send_code(tbl[i].pat);
         read_data_check("table_data");
      end
      read_check("table_status", R_STATUS, 32'h0000_0001);
      read_data_check("empty_read");
      read_check("empty_status", R_STATUS, 32'h0000_0001);

      // Register access rules
      wb_write(R_RSVD, 32'hFFFF_FFFF, 4'hF);
      read_check("rsvd_read", R_RSVD, 32'd0);
      read_check("ctrl_after_rsvd", R_CTRL, CTRL_EN1);
      wb_write(R_CTRL, 32'h0000_0000, 4'b1110);
      read_check("ctrl_sel_masked", R_CTRL, CTRL_EN1);

      // Ack is a single cycle even with stb held; dat_o is 0 outside ack
      acks = 0;
      first_ack = 1'b0;
      idle_dat = '0;
      wbs_adr_i = {28'd0, R_STATUS, 2'b00};
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'hF;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge wb_clk_i);
         #1;
         if (wbs_ack_o) begin
            acks++;
            if (i == 0) first_ack = 1'b1;
            check("held_stb_data", wbs_dat_o, 32'h0000_0001);
         end else begin
            idle_dat = idle_dat | wbs_dat_o;
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);
      check("held_stb_acks", acks, 32'd1);
      check("ack_latency", {31'd0, first_ack}, 32'd1);
      check("dat_without_ack", idle_dat, 32'd0);

      // Abort: start, 5 strobes, start, 12 strobes of 1
      do_reset();
      wb_write(R_CTRL, 32'h0000_0001, 4'hF);
      pulse_start();
      send_bits(12'hFFF, 5);
      pulse_start();
      send_bits(12'hFFF, 12);
      repeat (2) @(negedge wb_clk_i);
      model_push(12'hFFF);
      read_check("abort_status", R_STATUS, 32'h0001_0010);
      read_data_check("abort_data");

      // Abort counter saturates at 255
      pulse_start();
      repeat (260) pulse_start();
      read_check("abort_sat", R_STATUS, 32'h00FF_0001);

      // Reset mid-COLLECT discards the partial code
      do_reset();
      wb_write(R_CTRL, 32'h0000_0001, 4'hF);
      pulse_start();
      send_bits(12'h0AA, 5);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      read_check("midrst_status", R_STATUS, 32'h0000_0001);
      read_check("midrst_ctrl", R_CTRL, CTRL_RST);
      // FSM must be back in IDLE: strobes without start push nothing
      wb_write(R_CTRL, 32'h0000_0001, 4'hF);
      send_bits(12'hFFF, 12);
      repeat (2) @(negedge wb_clk_i);
      read_check("midrst_idle", R_STATUS, 32'h0000_0001);

      // Overflow: 9 codes, no reads
      do_reset();
      wb_write(R_CTRL, 32'h0000_0001, 4'hF);
      for (int i = 0; i < 9; i++) begin
         p = 12'($urandom_range(0, 4095));
         model_push(p);
         send_code(p);
      end
      read_check("ovf_status", R_STATUS, 32'h0000_0082);
      for (int i = 0; i < 8; i++) read_data_check("ovf_drain");
      read_data_check("ovf_empty_read");
      wb_write(R_CTRL, 32'h0000_0003, 4'h1);
      read_check("ovf_cleared", R_STATUS, 32'h0000_0001);

      // Push to full FIFO in the same cycle as a DATA pop
      do_reset();
      wb_write(R_CTRL, 32'h0000_0001, 4'hF);
      for (int i = 0; i < 8; i++) begin
         p = 12'($urandom_range(0, 4095));
         model_push(p);
         send_code(p);
      end
      p = 12'($urandom_range(0, 4095));
      pulse_start();
      send_bits(p, 11);
      cmp_i = p[11];
      repeat (2) @(negedge wb_clk_i);
      cmp_strobe_i = 1'b1;
      @(negedge wb_clk_i);
      cmp_strobe_i = 1'b0;
      // now in the PUSH cycle: the read is accepted on the push edge
      exp_q.push_back({16'd0, m_tag, p});
      m_tag = m_tag + 4'd1;
      read_data_check("pushpop_data");
      read_check("pushpop_status", R_STATUS, 32'h0000_0080);
      for (int i = 0; i < 8; i++) read_data_check("pushpop_drain");
      read_check("pushpop_empty", R_STATUS, 32'h0000_0001);

      // Interrupt
      do_reset();
`ifdef RLBP_READER_IRQ_EN
      wb_write(R_CTRL, 32'h0000_0021, 4'hF);
      read_check("irq_ctrl", R_CTRL, 32'h0000_0021);
      model_push(12'h111);
      send_code(12'h111);
      @(negedge wb_clk_i);
      check("irq_lvl1", {31'd0, irq_o}, 32'd0);
      model_push(12'h222);
      send_code(12'h222);
      @(negedge wb_clk_i);
      check("irq_lvl2", {31'd0, irq_o}, 32'd1);
      read_data_check("irq_pop");
      check("irq_after_pop", {31'd0, irq_o}, 32'd0);
`else
      wb_write(R_CTRL, 32'h0000_00F1, 4'hF);
      read_check("irq_thr_ro", R_CTRL, 32'h0000_0001);
      for (int i = 0; i < 5; i++) send_code(12'h555);
      @(negedge wb_clk_i);
      check("irq_tied", {31'd0, irq_o}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
